plab4_net_domain_link_arb: RTL and testbench

Two-domain link scheduler for the separated-domain ring network. It sits at the sending side of each inter-router link. It multiplexes the domain-1 and domain-2 message streams (control message plus data payload) onto the single physical link that feeds the per-link domain demux. In secure mode it enforces strict time-division slots, so one domain's traffic cannot change when the other domain is allowed to send. In shared mode it falls back to work-conserving round-robin.

---
 rtl/plab4_net_domain_link_arb.sv | 111 +++++++++++
 tb/tb_plab4_net_domain_link_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/plab4_net_domain_link_arb.sv
// Two-domain link scheduler for the separated-domain ring network.
// Multiplexes the domain-1 and domain-2 message streams onto one physical link.
// In secure mode (mode=1) the link is granted by strict time-division slots
// owned alternately by d1 and d2. In shared mode (mode=0) it falls back to
// work-conserving round-robin.
//
// Ports:
//   clk, reset (async, active-low)
//   req                       mode request, sampled at each slot boundary
//   in_val_dN / in_rdy_dN     per-domain handshake
//   in_msg_control_dN / in_msg_data_dN   per-domain message
//   out_val / out_rdy         link handshake
//   out_msg_control / out_msg_data       link message (combinational mux)
//   out_domain                granted domain, drives the demux select
//   slot_owner, mode          current TDM slot owner and active mode
module plab4_net_domain_link_arb #(
  parameter int unsigned p_payload_cnbits = 32,
  parameter int unsigned p_payload_dnbits = 32,
  parameter int unsigned p_opaque_nbits   = 3,
  parameter int unsigned p_srcdest_nbits  = 3,
  parameter int unsigned p_slot_len       = 4,
  localparam int unsigned m = p_payload_cnbits + p_opaque_nbits + 2 * p_srcdest_nbits
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req,
  input  logic                        in_val_d1,
  output logic                        in_rdy_d1,
  input  logic [m-1:0]                in_msg_control_d1,
  input  logic [p_payload_dnbits-1:0] in_msg_data_d1,
  input  logic                        in_val_d2,
  output logic                        in_rdy_d2,
  input  logic [m-1:0]                in_msg_control_d2,
  input  logic [p_payload_dnbits-1:0] in_msg_data_d2,
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic [m-1:0]                out_msg_control,
  output logic [p_payload_dnbits-1:0] out_msg_data,
  output logic                        out_domain,
  output logic                        slot_owner,
  output logic                        mode
);

  localparam int unsigned CW = (p_slot_len > 1) ? $clog2(p_slot_len) : 1;
  localparam logic [CW-1:0] LAST = CW'(p_slot_len - 1);

  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic          slot_owner_q, slot_owner_d;
  logic          mode_q, mode_d;
  logic          rr_ptr_q, rr_ptr_d;

  logic          slot_wrap_c;
  logic          grant_c;
  logic          sel_val_c;
  logic          fire_c;

  // State register; reset lands in slot 0, owner d1, secure mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt_q   <= '0;
      slot_owner_q <= 1'b0;
      mode_q       <= 1'b1;
      rr_ptr_q     <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      slot_owner_q <= slot_owner_d;
      mode_q       <= mode_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  // Next state: free-running slot timer, mode latched only at slot boundaries,
  // round-robin pointer advances only on shared-mode transfers.
  always_comb begin : next_state
    slot_wrap_c  = (slot_cnt_q == LAST);
    slot_cnt_d   = slot_cnt_q + CW'(1);
    slot_owner_d = slot_owner_q;
    mode_d       = mode_q;
    rr_ptr_d     = rr_ptr_q;
    if (slot_wrap_c) begin
      slot_cnt_d   = '0;
      slot_owner_d = ~slot_owner_q;
      mode_d       = req;
    end
    if (!mode_q && fire_c) begin
      rr_ptr_d = ~grant_c;
    end
  end

  // Grant and datapath mux. In secure mode the grant ignores in_val so one
  // domain's traffic cannot influence the other's handshake timing.
  always_comb begin : outputs
    grant_c = slot_owner_q;
    if (!mode_q) begin
      if (in_val_d1 ^ in_val_d2) grant_c = in_val_d2;
      else                       grant_c = rr_ptr_q;
    end
    sel_val_c       = grant_c ? in_val_d2 : in_val_d1;
    out_val         = reset & sel_val_c;
    in_rdy_d1       = reset & ~grant_c & out_rdy;
    in_rdy_d2       = reset &  grant_c & out_rdy;
    fire_c          = out_val & out_rdy;
    out_msg_control = grant_c ? in_msg_control_d2 : in_msg_control_d1;
    out_msg_data    = grant_c ? in_msg_data_d2    : in_msg_data_d1;
    out_domain      = grant_c;
  end

  assign slot_owner = slot_owner_q;
  assign mode       = mode_q;

endmodule

// File: tb/tb_plab4_net_domain_link_arb.sv
// Self-checking bench for plab4_net_domain_link_arb. Two instances (slot
// lengths 4 and 1) share the same stimulus; a slot/cycle-count model predicts
// every output on every cycle, and directed scenarios pin literal values.
module tb_plab4_net_domain_link_arb;

  localparam int unsigned CN = 32;
  localparam int unsigned DN = 32;
  localparam int unsigned ON = 3;
  localparam int unsigned SN = 3;
  localparam int unsigned M  = CN + ON + 2 * SN;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          v1, v2, out_rdy;
  logic [M-1:0]  c1, c2;
  logic [DN-1:0] d1, d2;

  logic [1:0]    o_val, o_rdy1, o_rdy2, o_dom, o_own, o_mode;
  logic [M-1:0]  o_ctl [2];
  logic [DN-1:0] o_dat [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance
  int t_m   [2];
  bit mode_m[2];
  bit rr_m  [2];
  int len_m [2];

  // Samples taken at the last negedge, for directed literal checks
  logic [1:0] s_val, s_rdy1, s_dom, s_mode;
  logic [M-1:0] s_ctl0;

  always #5 clk = ~clk;

  plab4_net_domain_link_arb #(.p_payload_cnbits(CN), .p_payload_dnbits(DN),
    .p_opaque_nbits(ON), .p_srcdest_nbits(SN), .p_slot_len(4)) dut4 (
    .clk(clk), .reset(reset), .req(req),
    .in_val_d1(v1), .in_rdy_d1(o_rdy1[0]), .in_msg_control_d1(c1), .in_msg_data_d1(d1),
    .in_val_d2(v2), .in_rdy_d2(o_rdy2[0]), .in_msg_control_d2(c2), .in_msg_data_d2(d2),
    .out_val(o_val[0]), .out_rdy(out_rdy), .out_msg_control(o_ctl[0]), .out_msg_data(o_dat[0]),
    .out_domain(o_dom[0]), .slot_owner(o_own[0]), .mode(o_mode[0]));

  plab4_net_domain_link_arb #(.p_payload_cnbits(CN), .p_payload_dnbits(DN),
    .p_opaque_nbits(ON), .p_srcdest_nbits(SN), .p_slot_len(1)) dut1 (
    .clk(clk), .reset(reset), .req(req),
    .in_val_d1(v1), .in_rdy_d1(o_rdy1[1]), .in_msg_control_d1(c1), .in_msg_data_d1(d1),
    .in_val_d2(v2), .in_rdy_d2(o_rdy2[1]), .in_msg_control_d2(c2), .in_msg_data_d2(d2),
    .out_val(o_val[1]), .out_rdy(out_rdy), .out_msg_control(o_ctl[1]), .out_msg_data(o_dat[1]),
    .out_domain(o_dom[1]), .slot_owner(o_own[1]), .mode(o_mode[1]));

  task automatic chk(input string nm, input int inst, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[len%0d] got %h want %h t=%0t", nm, len_m[inst], act, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already driven; check at negedge, advance the
  // model at the posedge, return 1 time unit after it.
  task automatic run_cycle();
    bit own [2];
    bit g   [2];
    bit ev  [2];
    bit in_rst;
    @(negedge clk);
    in_rst = !reset;
    for (int i = 0; i < 2; i++) begin
      if (in_rst) begin
        t_m[i] = 0; mode_m[i] = 1'b1; rr_m[i] = 1'b0;
      end
      own[i] = ((t_m[i] / len_m[i]) % 2) == 1;
      if (mode_m[i])    g[i] = own[i];
      else if (v1 != v2) g[i] = v2;
      else               g[i] = rr_m[i];
      ev[i] = !in_rst && (g[i] ? v2 : v1);
      chk("out_val",    i, 64'(o_val[i]),  64'(ev[i]));
      chk("in_rdy_d1",  i, 64'(o_rdy1[i]), 64'(!in_rst && !g[i] && out_rdy));
      chk("in_rdy_d2",  i, 64'(o_rdy2[i]), 64'(!in_rst &&  g[i] && out_rdy));
      chk("out_domain", i, 64'(o_dom[i]),  64'(g[i]));
      chk("slot_owner", i, 64'(o_own[i]),  64'(own[i]));
      chk("mode",       i, 64'(o_mode[i]), 64'(mode_m[i]));
      chk("out_ctl",    i, 64'(o_ctl[i]),  64'(g[i] ? c2 : c1));
      chk("out_data",   i, 64'(o_dat[i]),  64'(g[i] ? d2 : d1));
    end
    s_val = o_val; s_rdy1 = o_rdy1; s_dom = o_dom; s_mode = o_mode; s_ctl0 = o_ctl[0];
    @(posedge clk);
    if (!in_rst) begin
      for (int i = 0; i < 2; i++) begin
        if (!mode_m[i] && ev[i] && out_rdy) rr_m[i] = !g[i];
        if ((t_m[i] % len_m[i]) == len_m[i] - 1) mode_m[i] = req;
        t_m[i]++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run_cycle();
    reset = 1'b1;
  endtask

  task automatic rand_msgs();
    c1 = M'({$urandom, $urandom});
    c2 = M'({$urandom, $urandom});
    d1 = $urandom;
    d2 = $urandom;
  endtask

  initial begin
    logic [7:0] pat4;
    logic [7:0] pat1;
    logic [M-1:0] held;
    pat4 = 8'b1111_0000;
    pat1 = 8'b1010_1010;
    len_m[0] = 4; len_m[1] = 1;
    for (int i = 0; i < 2; i++) begin t_m[i] = 0; mode_m[i] = 1'b1; rr_m[i] = 1'b0; end
    reset = 1'b0; req = 1'b1; v1 = 1'b1; v2 = 1'b1; out_rdy = 1'b1;
    rand_msgs();

    // Reset held with traffic pending: handshakes forced low
    @(posedge clk); #1;
    run_cycle();
    run_cycle();
    for (int i = 0; i < 2; i++) begin
      chk("rst_val",  i, 64'(s_val[i]),  64'd0);
      chk("rst_rdy1", i, 64'(s_rdy1[i]), 64'd0);
      chk("rst_mode", i, 64'(s_mode[i]), 64'd1);
    end
    reset = 1'b1;

    // Secure mode, both valid: d1 owns cycles 0-3, d2 owns 4-7
    for (int c = 0; c < 8; c++) begin
      rand_msgs();
      run_cycle();
      chk("tdm_dom", 0, 64'(s_dom[0]), 64'(pat4[c]));
      chk("tdm_dom", 1, 64'(s_dom[1]), 64'(pat1[c]));
      chk("tdm_val", 0, 64'(s_val[0]), 64'd1);
    end

    // Isolation: only d2 valid, it must wait for its own slot
    do_reset();
    v1 = 1'b0; v2 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rand_msgs();
      run_cycle();
      chk("iso_val",  0, 64'(s_val[0]),  64'(c >= 4));
      chk("iso_rdy1", 0, 64'(s_rdy1[0]), 64'(c < 4));
      if (c >= 4) chk("iso_dom", 0, 64'(s_dom[0]), 64'd1);
    end

    // Backpressure at slot end: stalled d1 message waits a full d2 slot
    do_reset();
    v1 = 1'b1; v2 = 1'b0;
    rand_msgs();
    held = c1;
    for (int c = 0; c < 9; c++) begin
      out_rdy = (c >= 4);
      run_cycle();
      if (c >= 4 && c < 8) begin
        chk("bp_val",  0, 64'(s_val[0]),  64'd0);
        chk("bp_rdy1", 0, 64'(s_rdy1[0]), 64'd0);
      end
    end
    chk("bp_fire_val", 0, 64'(s_val[0] & s_rdy1[0]), 64'd1);
    chk("bp_fire_ctl", 0, 64'(s_ctl0), 64'(held));

    // Mode switch requested mid-slot takes effect at the next slot
    do_reset();
    v1 = 1'b1; v2 = 1'b1; out_rdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req = (c == 0);
      rand_msgs();
      run_cycle();
      chk("sw_mode", 0, 64'(s_mode[0]), 64'(c < 4));
      if (c >= 4) chk("sw_dom", 0, 64'(s_dom[0]), 64'((c - 4) % 2));
    end

    // Shared mode is work-conserving across slot boundaries
    v1 = 1'b1; v2 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rand_msgs();
      run_cycle();
      chk("wc_fire", 0, 64'(s_val[0] & s_rdy1[0]), 64'd1);
      chk("wc_dom",  0, 64'(s_dom[0]), 64'd0);
    end

    // Random traffic, mode requests and occasional asynchronous resets
    for (int c = 0; c < 800; c++) begin
      int thr;
      thr = (c < 400) ? 8 : 2;
      req     = ($urandom_range(0, 9) < thr);
      v1      = ($urandom_range(0, 3) != 0);
      v2      = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      rand_msgs();
      if ($urandom_range(0, 63) == 0) begin
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
          chk("arst_val",  i, 64'(o_val[i]),  64'd0);
          chk("arst_own",  i, 64'(o_own[i]),  64'd0);
          chk("arst_mode", i, 64'(o_mode[i]), 64'd1);
        end
        run_cycle();
        reset = 1'b1;
      end else begin
        run_cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
